// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: instruction sequencer driving MAC datapath strobes and status byte.
// Optional busy-cycle counter enabled by defining MAC_SEQ_PERF_EN.
module mac_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       Inputs,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              acc_clr,
  output logic              mac_en,
  output logic [ADDR_W-1:0] op_addr,
  output logic              res_we,
  output logic              busy,
  output logic [7:0]        Control_out,
  output logic [15:0]       perf_cycles
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, STORE} state_e;
  state_e            state_q, state_d;
  logic [3:0]        op_q, ret_q, ret_d;
  logic [7:0]        len_q, cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, addr_q, addr_d, base_w;
  logic              err_q, err_d, retire, accept, unused_bits;
  assign base_w      = ADDR_W'(Inputs[19:12]);
  assign unused_bits = ^Inputs[11:0];
  // in_ready is also held low under reset so nothing is accepted while rst wins
  assign in_ready    = en & ~rst & (state_q == IDLE);
  assign accept      = in_ready & in_valid;
  assign busy        = state_q != IDLE;
  assign acc_clr     = en & (state_q == CLEAR);
  assign mac_en      = en & (state_q == RUN);
  assign res_we      = en & (state_q == STORE);
  assign op_addr     = addr_q;
  assign Control_out = {state_q, err_q, ret_q};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    retire  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: if (accept) begin
          case (Inputs[31:28])
            4'h0: retire = 1'b1;
            4'h1, 4'h3: state_d = CLEAR;
            4'h2: begin
              retire  = Inputs[27:20] == 8'd0;
              state_d = retire ? IDLE : RUN;
              addr_d  = retire ? addr_q : base_w;
              cnt_d   = 8'd0;
            end
            4'h4: state_d = STORE;
            default: err_d = 1'b1;
          endcase
        end
        CLEAR: begin
          retire  = !(op_q == 4'h3 && len_q != 8'd0);
          state_d = retire ? IDLE : RUN;
          addr_d  = retire ? addr_q : base_q;
          cnt_d   = 8'd0;
        end
        RUN: if (cnt_q == len_q - 8'd1) begin
          cnt_d   = 8'd0;
          retire  = PIPE_LAT == 0;
          state_d = retire ? IDLE : DRAIN;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
        DRAIN: begin
          retire  = cnt_q == 8'(PIPE_LAT - 1);
          state_d = retire ? IDLE : DRAIN;
          cnt_d   = retire ? 8'd0 : cnt_q + 8'd1;
        end
        STORE: begin
          retire  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    ret_d = ret_q + 4'(retire);
  end
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      if (accept) begin
        op_q   <= Inputs[31:28];
        len_q  <= Inputs[27:20];
        base_q <= base_w;
      end
    end
  end
`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge Clk) begin
    if (rst) perf_q <= '0;
    else if (en && busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'h0000;
`endif
endmodule
